// File: rtl/shared_mem_arbiter_if.sv
// Bundle of the core-side request/response signals and the shared-memory port
// seen by shared_mem_arbiter. The arbiter uses the slave view. The core array
// and the SRAM model use the master view.
interface shared_mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8
);
    localparam int GW = $clog2(NUM_CORES);

    // core side
    logic [NUM_CORES-1:0]        mem_req;
    logic [NUM_CORES-1:0]        req_we;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES*DATA_W-1:0] req_wdata;
    logic [NUM_CORES-1:0]        val_data;
    logic [DATA_W-1:0]           core_rdata;
    logic                        busy;
    logic [GW-1:0]               grant_id;

    // memory side
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    // FSM state for observation: 0=IDLE 1=ISSUE 2=WAIT 3=RESP
    logic [1:0]                  dbg_state;

    modport slave (
        input  mem_req, req_we, req_addr, req_wdata, mem_rdata,
        output val_data, core_rdata, busy, grant_id,
        output mem_en, mem_we, mem_addr, mem_wdata, dbg_state
    );

    modport master (
        output mem_req, req_we, req_addr, req_wdata, mem_rdata,
        input  val_data, core_rdata, busy, grant_id,
        input  mem_en, mem_we, mem_addr, mem_wdata, dbg_state
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter between NUM_CORES cores and one single-port shared SRAM.
//
// Handshake: a core raises mem_req[i] with req_we/req_addr/req_wdata valid and
// holds it until val_data[i] pulses for one cycle, then drops it the next
// cycle. Request fields are sampled only in the IDLE cycle that grants the
// core; later changes are ignored. A granted access always completes even if
// mem_req falls. The memory sees one mem_en cycle per grant and returns
// mem_rdata exactly MEM_LAT cycles later, with no backpressure.
module shared_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MEM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    shared_mem_arbiter_if.slave   bus
);
    localparam int GW = $clog2(NUM_CORES);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t                state;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         grant_q;
    logic [LW-1:0]         lat_cnt;
    logic [NUM_CORES-1:0]  val_data_q;
    logic [DATA_W-1:0]     core_rdata_q;
    logic                  busy_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    logic                  pick_valid;
    logic [GW-1:0]         pick_idx;
    logic [GW-1:0]         cand;

    // Round-robin pick: first requesting core after last_grant, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_CORES);
            if (!pick_valid && bus.mem_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Transaction FSM: grant, issue one memory strobe, wait out the latency, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GW'(NUM_CORES - 1);
            grant_q      <= GW'(NUM_CORES - 1);
            lat_cnt      <= '0;
            val_data_q   <= '0;
            core_rdata_q <= '0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q     <= pick_idx;
                        mem_we_q    <= bus.req_we[pick_idx];
                        mem_addr_q  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_wdata_q <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    lat_cnt  <= LW'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        core_rdata_q <= bus.mem_rdata;
                        val_data_q   <= NUM_CORES'(1) << grant_q;
                        state        <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    val_data_q <= '0;
                    last_grant <= grant_q;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.val_data   = val_data_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.dbg_state  = state;
endmodule
